// File: rtl/collector_drain.sv
// collector_drain: drains the MLP collector output FIFO onto an
// AXI-Stream-style master with tlast framing, frame checksum and counters.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   enable            gates new FIFO reads; buffered words still drain
//   ofifo_rdy/ren     FIFO non-empty / pop strobe (data one cycle later)
//   ofifo_rdata       FIFO read data
//   m_tdata/tvalid/
//   m_tready/tlast    output stream, tlast every FRAME_LEN words
//   frame_sum(_valid) modular sum of the last frame, 1-cycle pulse
//   word_count        words accepted downstream, saturating
//   frame_count       frames completed, saturating
module collector_drain #(
  parameter int DATA_WIDTH = 64,
  parameter int FRAME_LEN  = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ofifo_rdy,
  output logic                  ofifo_ren,
  input  logic [DATA_WIDTH-1:0] ofifo_rdata,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic [DATA_WIDTH-1:0] frame_sum,
  output logic                  frame_sum_valid,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  localparam int BW =
    (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [1:0]            occ;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [BW-1:0]         beat;
  logic [DATA_WIDTH-1:0] acc;
  logic                  pop;
  logic [2:0]            credit;

  assign m_tvalid = (occ != 2'd0);
  assign m_tdata  = head;
  assign m_tlast  = m_tvalid & (beat == LAST);
  assign pop      = m_tvalid & m_tready;

  // Words already owned (buffered + in flight). A pop this cycle
  // frees a slot, so reads keep 1 word/cycle under full throughput.
  assign credit = {1'b0, occ} + {2'b00, inflight};
  assign ofifo_ren = enable & ofifo_rdy & ~reset &
                     (credit < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk) begin
    if (reset) begin
      occ             <= 2'd0;
      inflight        <= 1'b0;
      head            <= '0;
      tail            <= '0;
      beat            <= '0;
      acc             <= '0;
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
      word_count      <= '0;
      frame_count     <= '0;
    end else begin
      inflight        <= ofifo_ren;
      frame_sum_valid <= 1'b0;

      // head is the output register; tail only ever holds the
      // second-oldest word, so head stays stable while stalled.
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) head <= ofifo_rdata;
          else             tail <= ofifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= ofifo_rdata;
          end else begin
            head <= tail;
            tail <= ofifo_rdata;
          end
        end
        default: ;
      endcase

      if (pop) begin
        if (word_count != CMAX)
          word_count <= word_count + CNT_WIDTH'(1);
        if (m_tlast) begin
          beat            <= '0;
          acc             <= '0;
          frame_sum       <= acc + m_tdata;
          frame_sum_valid <= 1'b1;
          if (frame_count != CMAX)
            frame_count <= frame_count + CNT_WIDTH'(1);
        end else begin
          beat <= beat + BW'(1);
          acc  <= acc + m_tdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_collector_drain.sv
// tb_collector_drain: scoreboard bench for collector_drain.
// Directed stream/backpressure/wrap/enable/reset plus random traffic.
module tb_collector_drain;

  localparam int DW = 64;
  localparam int FL = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          ofifo_rdy = 1'b0;
  logic          ofifo_ren;
  logic [DW-1:0] ofifo_rdata = '0;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic          m_tlast;
  logic [DW-1:0] frame_sum;
  logic          frame_sum_valid;
  logic [CW-1:0] word_count;
  logic [CW-1:0] frame_count;

  logic          s_ren;
  logic [DW-1:0] s_rdata = '0;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic [DW-1:0] s_fs;
  logic          s_fsv;
  logic [2:0]    s_wc;
  logic [2:0]    s_fc;

  collector_drain #(
    .DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ofifo_rdy(ofifo_rdy), .ofifo_ren(ofifo_ren),
    .ofifo_rdata(ofifo_rdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_sum(frame_sum),
    .frame_sum_valid(frame_sum_valid),
    .word_count(word_count), .frame_count(frame_count)
  );

  collector_drain #(
    .DATA_WIDTH(DW), .FRAME_LEN(1), .CNT_WIDTH(3)
  ) dut_sat (
    .clk(clk), .reset(reset), .enable(1'b1),
    .ofifo_rdy(1'b1), .ofifo_ren(s_ren),
    .ofifo_rdata(s_rdata),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid),
    .m_tready(1'b1), .m_tlast(s_tlast),
    .frame_sum(s_fs), .frame_sum_valid(s_fsv),
    .word_count(s_wc), .frame_count(s_fc)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic          ren_s = 1'b0;
  logic          rdy_gate = 1'b0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] sat3(int n);
    return (n > 7) ? 3'd7 : 3'(n);
  endfunction

  // Collector FIFO model: one-cycle read latency. Every word it
  // hands out is what the stream must later carry, in order.
  always @(posedge clk) begin
    s_rdata <= {$urandom, $urandom};
    if (ren_s && src_q.size() != 0) begin
      ofifo_rdata <= src_q[0];
      exp_q.push_back(src_q[0]);
      void'(src_q.pop_front());
    end
  end

  // Monitor / reference model, sampled on the falling edge.
  int            cyc = 0;
  int            pops = 0;
  int            frames = 0;
  int            beat = 0;
  int            rens = 0;
  int            first_ren = -1;
  int            s_pops = 0;
  bit            seen_val = 0;
  bit            chk_rst = 0;
  bit            prev_stall = 0;
  bit            exp_fsv = 0;
  bit            next_fsv = 0;
  logic [DW-1:0] acc = '0;
  logic [DW-1:0] exp_fs = '0;
  logic [DW-1:0] prev_data = '0;
  logic [DW-1:0] mon_w;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      pops = 0; frames = 0; beat = 0; rens = 0;
      acc = '0; exp_fs = '0; exp_fsv = 0;
      first_ren = -1; seen_val = 0;
      prev_stall = 0; chk_rst = 1;
      s_pops = 0; ren_s = 1'b0;
    end else begin
      if (chk_rst) begin
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_fsum", frame_sum, 0);
        chk("rst_fsv", frame_sum_valid, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_fc", frame_count, 0);
        chk_rst = 0;
      end
      chk("word_count", word_count, pops);
      chk("frame_count", frame_count, frames);
      chk("fsum_valid", frame_sum_valid, exp_fsv);
      chk("frame_sum", frame_sum, exp_fs);
      chk("tlast", m_tlast,
          m_tvalid && (beat == FL - 1));
      chk("outstanding", (rens - pops) <= 2, 1);
      if (!enable || !ofifo_rdy)
        chk("ren_gated", ofifo_ren, 0);
      if (prev_stall) begin
        chk("stall_valid", m_tvalid, 1);
        chk("stall_data", m_tdata, prev_data);
      end
      if (ofifo_ren && first_ren < 0) first_ren = cyc;
      if (m_tvalid && !seen_val) begin
        seen_val = 1;
        chk("latency", cyc - first_ren, 2);
      end
      next_fsv = 0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pop", 1, 0);
        end else begin
          mon_w = exp_q.pop_front();
          chk("tdata", m_tdata, mon_w);
          acc = acc + mon_w;
        end
        pops++;
        beat++;
        if (beat == FL) begin
          beat = 0;
          exp_fs = acc;
          acc = '0;
          frames++;
          next_fsv = 1;
        end
      end
      exp_fsv = next_fsv;
      prev_stall = m_tvalid && !m_tready;
      prev_data = m_tdata;
      rens += int'(ofifo_ren);
      ren_s = ofifo_ren;

      chk("sat_wc", s_wc, sat3(s_pops));
      chk("sat_fc", s_fc, sat3(s_pops));
      chk("sat_tlast", s_tlast, s_tvalid);
      if (s_tvalid) s_pops++;
    end
  end

  // Stimulus: set inputs, then step() finalises rdy and
  // advances to 1 time unit after the next rising edge.
  task automatic step();
    ofifo_rdy = rdy_gate && (src_q.size() != 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm, bit bp, int budget);
    int k;
    k = 0;
    enable = 1'b1;
    rdy_gate = 1'b1;
    while ((src_q.size() != 0 || exp_q.size() != 0 ||
            m_tvalid) && k < budget) begin
      m_tready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      step();
      k++;
    end
    if (k >= budget) chk({nm, "_timeout"}, 1, 0);
    m_tready = 1'b1;
  endtask

  initial begin
    int first;
    int last;
    int nv;
    int nren;
    logic [CW-1:0] wc0;

    repeat (3) step();
    reset = 1'b0;
    step();

    // Full-rate stream of 1..8.
    for (int i = 1; i <= 8; i++) src_q.push_back(64'(i));
    enable = 1'b1; rdy_gate = 1'b1; m_tready = 1'b1;
    first = -1; last = -1; nv = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (m_tvalid) begin
        if (first < 0) first = k;
        last = k;
        nv++;
      end
    end
    chk("p1_span", last - first, 7);
    chk("p1_nvalid", nv, 8);
    chk("p1_wc", word_count, 8);
    chk("p1_fc", frame_count, 2);
    chk("p1_fsum", frame_sum, 26);

    // Modular wrap of the checksum.
    src_q.push_back('1);
    src_q.push_back(64'd2);
    src_q.push_back(64'd0);
    src_q.push_back(64'd0);
    drain("wrap", 0, 50);
    chk("wrap_fsum", frame_sum, 1);

    // Backpressure 1,0,0,1 over 16 words.
    for (int i = 1; i <= 16; i++) src_q.push_back(64'(i));
    drain("bp", 1, 200);
    chk("bp_wc", word_count, 28);

    // Enable dropped with two words buffered.
    for (int i = 5; i <= 8; i++) src_q.push_back(64'(i));
    m_tready = 1'b0;
    repeat (4) step();
    enable = 1'b0;
    m_tready = 1'b1;
    wc0 = word_count;
    nren = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      nren += int'(ofifo_ren);
    end
    chk("en_ren", nren, 0);
    chk("en_drained", word_count - wc0, 2);
    drain("en", 0, 50);
    chk("en_fsum", frame_sum, 26);
    chk("en_fc", frame_count, 8);

    // Reset in the middle of a frame with words in flight.
    for (int i = 1; i <= 3; i++) src_q.push_back(64'(i + 40));
    m_tready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    src_q.delete();
    step();
    reset = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) src_q.push_back(64'(i));
    drain("rst", 0, 50);
    chk("rst_fsum2", frame_sum, 10);
    chk("rst_fc2", frame_count, 1);
    chk("rst_wc2", word_count, 4);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      m_tready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      rdy_gate = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 12 && $urandom_range(0, 1) == 1)
        src_q.push_back({$urandom, $urandom});
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        src_q.delete();
      end else begin
        reset = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    drain("rand", 0, 500);
    repeat (20) step();
    chk("sat_wc_final", s_wc, 7);
    chk("sat_fc_final", s_fc, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
